int_controller: RTL and testbench

INT_CONTROLLER -- requirements
Module: int_controller

---
 rtl/int_controller.sv | 139 +++++++++++++
 tb/tb_int_controller.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// Interrupt controller: synchronizes and edge-detects four external lines, arbitrates them
// against INT instructions, and runs the REQ/SVC/RET handshake with the scheduler.
module int_controller (
    input  logic        inti_clk,
    input  logic        inti_rst,
    input  logic [3:0]  inti_irq,
    input  logic        inti_soft_int,
    input  logic [3:0]  inti_soft_id,
    input  logic        inti_eret,
    input  logic [15:0] inti_pc,
    input  logic        inti_mask_we,
    input  logic [3:0]  inti_mask_data,
    input  logic        inti_ack,
    output logic        into_int,
    output logic [3:0]  into_int_id,
    output logic [15:0] into_epc,
    output logic        into_busy,
    output logic [3:0]  into_pending
);

    typedef enum logic [1:0] {IDLE, REQ, SVC, RET} state_t;

    state_t      state, state_next;
    logic [3:0]  irq_p0, irq_p1, irq_p2;
    logic [1:0]  fill;
    logic [3:0]  armed;
    logic [3:0]  pending, mask;
    logic [3:0]  edge_det, active, clr;
    logic [3:0]  req_id, load_id;
    logic [15:0] req_epc;
    logic        req_hw, load_hw, load;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd3;
        for (int i = 3; i >= 0; i--)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    // Stage p0/p1: two-flop synchronizer; p2 delays p1 for edge detection.
    // A line only arms once it has been seen low after the synchronizer has refilled,
    // so a line already high at reset release never produces a request.
    always_ff @(posedge inti_clk or posedge inti_rst) begin
        if (inti_rst) begin
            irq_p0 <= '0;
            irq_p1 <= '0;
            irq_p2 <= '0;
            fill   <= '0;
            armed  <= '0;
        end else begin
            irq_p0 <= inti_irq;
            irq_p1 <= irq_p0;
            irq_p2 <= irq_p1;
            fill   <= {fill[0], 1'b1};
            armed  <= armed | ({4{fill[1]}} & ~irq_p1);
        end
    end

    assign edge_det = irq_p1 & ~irq_p2 & armed;
    assign active   = pending & mask;

    // Pending/mask stage: set wins over the service clear in the same cycle.
    always_ff @(posedge inti_clk or posedge inti_rst) begin
        if (inti_rst) begin
            pending <= '0;
            mask    <= 4'b1111;
        end else begin
            pending <= (pending & ~clr) | edge_det;
            if (inti_mask_we)
                mask <= inti_mask_data;
        end
    end

    always_ff @(posedge inti_clk or posedge inti_rst) begin
        if (inti_rst) begin
            state   <= IDLE;
            req_id  <= '0;
            req_epc <= '0;
            req_hw  <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                req_id  <= load_id;
                req_epc <= inti_pc;
                req_hw  <= load_hw;
            end
        end
    end

    always_comb begin
        state_next  = state;
        load        = 1'b0;
        load_id     = req_id;
        load_hw     = 1'b0;
        clr         = '0;
        into_int    = 1'b0;
        into_busy   = 1'b1;
        into_int_id = req_id;
        case (state)
            IDLE: begin
                into_busy = 1'b0;
                if (inti_soft_int && !inti_soft_id[3]) begin
                    state_next = REQ;
                    load       = 1'b1;
                    load_id    = inti_soft_id;
                end else if (|active) begin
                    state_next = REQ;
                    load       = 1'b1;
                    load_id    = {2'b10, lowest_idx(active)};
                    load_hw    = 1'b1;
                end
            end
            REQ: begin
                into_int = 1'b1;
                if (inti_ack) begin
                    state_next = SVC;
                    if (req_hw)
                        clr = 4'b0001 << req_id[1:0];
                end
            end
            SVC: begin
                if (inti_eret)
                    state_next = RET;
            end
            RET: begin
                into_int    = 1'b1;
                into_int_id = 4'b1111;
                if (inti_ack)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign into_epc     = req_epc;
    assign into_pending = pending;

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: expected requests are queued when stimulus is
// driven and compared when into_int is raised.
module tb_int_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        soft_int;
    logic [3:0]  soft_id;
    logic        eret;
    logic [15:0] pc;
    logic        mask_we;
    logic [3:0]  mask_data;
    logic        ack;
    logic        int_o;
    logic [3:0]  int_id;
    logic [15:0] epc;
    logic        busy;
    logic [3:0]  pending;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] epc;
    } exp_t;
    exp_t sb[$];

    int_controller dut (
        .inti_clk       (clk),
        .inti_rst       (rst),
        .inti_irq       (irq),
        .inti_soft_int  (soft_int),
        .inti_soft_id   (soft_id),
        .inti_eret      (eret),
        .inti_pc        (pc),
        .inti_mask_we   (mask_we),
        .inti_mask_data (mask_data),
        .inti_ack       (ack),
        .into_int       (int_o),
        .into_int_id    (int_id),
        .into_epc       (epc),
        .into_busy      (busy),
        .into_pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_req(input logic [3:0] id, input logic [15:0] e);
        sb.push_back({id, e});
    endtask

    task automatic pop_req(input string tag);
        exp_t x;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            x = sb.pop_front();
            check({tag, "_id"}, 32'(int_id), 32'(x.id));
            check({tag, "_epc"}, 32'(epc), 32'(x.epc));
        end
    endtask

    task automatic wait_int(input string tag);
        int n = 0;
        while (int_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_int"}, 32'(int_o), 32'd1);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = '0; soft_int = 1'b0; soft_id = '0; eret = 1'b0;
        pc = '0; mask_we = 1'b0; mask_data = '0; ack = 1'b0;
        tick(2);
        check("rst_int", 32'(int_o), 32'd0);
        check("rst_id", 32'(int_id), 32'd0);
        check("rst_epc", 32'(epc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        tick(4);

        // irq[2] latency and single service round trip
        irq = 4'b0100; pc = 16'h0040;
        push_req(4'hA, 16'h0040);
        tick(3);
        check("lat_edge3_int", 32'(int_o), 32'd0);
        check("lat_edge3_pending", 32'(pending), 32'h4);
        tick();
        check("lat_edge4_int", 32'(int_o), 32'd1);
        pop_req("irq2");
        pc = 16'h0050;
        tick();
        check("req_hold_epc", 32'(epc), 32'h0040);
        irq = 4'b0000;
        pulse_ack();
        check("svc_busy", 32'(busy), 32'd1);
        check("svc_int", 32'(int_o), 32'd0);
        check("svc_pending", 32'(pending), 32'd0);
        pulse_eret();
        check("ret_int", 32'(int_o), 32'd1);
        check("ret_id", 32'(int_id), 32'hF);
        check("ret_epc", 32'(epc), 32'h0040);
        pulse_ack();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_int", 32'(int_o), 32'd0);

        // two lines at once, then back-to-back
        irq = 4'b1010; pc = 16'h0100;
        push_req(4'h9, 16'h0100);
        wait_int("dual_first");
        pop_req("dual_first");
        pulse_ack();
        check("dual_pending", 32'(pending), 32'h8);
        pulse_eret();
        check("dual_ret_epc", 32'(epc), 32'h0100);
        pc = 16'h0200;
        push_req(4'hB, 16'h0200);
        pulse_ack();
        check("b2b_gap_int", 32'(int_o), 32'd0);
        tick();
        check("b2b_int", 32'(int_o), 32'd1);
        pop_req("b2b");
        pulse_ack();
        check("b2b_pending", 32'(pending), 32'd0);
        pulse_eret();
        pulse_ack();
        irq = 4'b0000;
        tick(2);

        // soft INT beats hardware edge, pending[0] survives
        irq = 4'b0001; pc = 16'h0300;
        tick(3);
        check("soft_pre_pending", 32'(pending), 32'h1);
        soft_int = 1'b1; soft_id = 4'h5;
        push_req(4'h5, 16'h0300);
        tick();
        soft_int = 1'b0; soft_id = 4'h0;
        check("soft_int", 32'(int_o), 32'd1);
        pop_req("soft");
        check("soft_pending", 32'(pending), 32'h1);
        pulse_ack();
        check("soft_svc_pending", 32'(pending), 32'h1);
        soft_int = 1'b1; soft_id = 4'h3;
        tick();
        soft_int = 1'b0;
        check("svc_soft_dropped", 32'(int_o), 32'd0);
        pulse_eret();
        pc = 16'h0310;
        push_req(4'h8, 16'h0310);
        pulse_ack();
        wait_int("after_soft");
        pop_req("after_soft");
        pulse_ack();
        pulse_eret();
        pulse_ack();
        irq = 4'b0000;
        tick(2);

        // soft id with bit 3 set and ERET in IDLE are ignored
        soft_int = 1'b1; soft_id = 4'hC; eret = 1'b1;
        tick();
        soft_int = 1'b0; soft_id = 4'h0; eret = 1'b0;
        tick(2);
        check("soft_id3_int", 32'(int_o), 32'd0);
        check("idle_eret_busy", 32'(busy), 32'd0);

        // masked line still latches pending
        mask_we = 1'b1; mask_data = 4'b1110;
        tick();
        mask_we = 1'b0;
        irq = 4'b0001; pc = 16'h0400;
        tick(6);
        check("masked_int", 32'(int_o), 32'd0);
        check("masked_pending", 32'(pending), 32'h1);
        mask_we = 1'b1; mask_data = 4'b1111;
        push_req(4'h8, 16'h0400);
        tick();
        mask_we = 1'b0;
        wait_int("unmask");
        pop_req("unmask");
        pulse_ack();
        check("unmask_pending", 32'(pending), 32'd0);
        pulse_eret();
        pulse_ack();
        irq = 4'b0000;
        tick(2);

        // reset mid-request; lines high at release are not edges
        irq = 4'b0010; pc = 16'h0500;
        push_req(4'h9, 16'h0500);
        wait_int("pre_rst");
        pop_req("pre_rst");
        #2 rst = 1'b1;
        #1;
        check("midrst_int", 32'(int_o), 32'd0);
        check("midrst_id", 32'(int_id), 32'd0);
        check("midrst_epc", 32'(epc), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        irq = 4'b1010;
        tick(2);
        rst = 1'b0;
        tick(8);
        check("rel_high_int", 32'(int_o), 32'd0);
        check("rel_high_pending", 32'(pending), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
